// File: rtl/register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : register_file_mp                                                |
// | Purpose  : NRD-read / NWR-write integer register file with busy scoreboard |
// |            and optional same-cycle write-to-read bypass.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module register_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                alloc_valid_i,
  input  logic [AW-1:0]       alloc_addr_i,
  input  logic                flush_i
);

  logic [XLEN-1:0]  w_regs     [NREGS];
  logic [XLEN-1:0]  w_hit_data [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_hit;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_regs[r]     = '0;
      assign w_hit_data[r] = '0;
      assign w_busy[r]     = 1'b0;
      assign w_hit[r]      = 1'b0;
    end else begin : g_live
      logic [XLEN-1:0] r_data;
      logic            r_busy;
      logic            w_wr_hit;
      logic [XLEN-1:0] w_wr_data;

      // Ascending scan so the highest-index matching port is the one kept.
      // Gated by reset_n so bypassed data is also forced to 0 during reset.
      always_comb begin
        w_wr_hit  = 1'b0;
        w_wr_data = '0;
        for (int j = 0; j < NWR; j++) begin
          if (reset_n && wr_en_i[j] && (wr_addr_i[j*AW +: AW] == AW'(r))) begin
            w_wr_hit  = 1'b1;
            w_wr_data = wr_data_i[j*XLEN +: XLEN];
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          if (w_wr_hit) begin
            r_data <= w_wr_data;
          end
          // A new allocation supersedes a completing write from the old producer.
          if (flush_i) begin
            r_busy <= 1'b0;
          end else if (alloc_valid_i && (alloc_addr_i == AW'(r))) begin
            r_busy <= 1'b1;
          end else if (w_wr_hit) begin
            r_busy <= 1'b0;
          end
        end
      end

      assign w_regs[r]     = r_data;
      assign w_hit_data[r] = w_wr_data;
      assign w_busy[r]     = r_busy;
      assign w_hit[r]      = w_wr_hit;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = rd_addr_i[k*AW +: AW];

    if (BYPASS != 0) begin : g_byp
      assign rd_data_o[k*XLEN +: XLEN] = w_hit[w_ra] ? w_hit_data[w_ra] : w_regs[w_ra];
      assign rd_busy_o[k]              = w_busy[w_ra] & ~w_hit[w_ra];
    end else begin : g_nobyp
      assign rd_data_o[k*XLEN +: XLEN] = w_regs[w_ra];
      assign rd_busy_o[k]              = w_busy[w_ra];
    end
  end

endmodule
`default_nettype wire
